// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage with a single instruction register,
//                control-flow redirect (GOTO/CALL/RETURN/RETFIE/RETLW), skip
//                squashing and a circular return-address stack with sticky
//                overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        skip,
  input  logic [13:0] rom_data,
  output logic [10:0] rom_addr,
  output logic [13:0] ir,
  output logic [10:0] ir_addr,
  output logic        ir_valid,
  output logic        stack_ovf,
  output logic        stack_unf
);

  localparam int c_PTR_W = $clog2(STACK_DEPTH);
  localparam int c_OCC_W = $clog2(STACK_DEPTH + 1);
  localparam logic [c_OCC_W-1:0] c_FULL  = c_OCC_W'(STACK_DEPTH);
  localparam logic [c_OCC_W-1:0] c_EMPTY = '0;
  localparam logic [13:0] c_NOP = 14'h0000;

  // Fetch and instruction registers
  logic [10:0] r_pc;
  logic [13:0] r_ir;
  logic [10:0] r_ir_addr;
  logic        r_ir_valid;

  // Return-address stack; entries are deliberately left out of reset
  logic [10:0]        r_stack [STACK_DEPTH];
  logic [c_PTR_W-1:0] r_sp;
  logic [c_OCC_W-1:0] r_occ;
  logic               r_ovf;
  logic               r_unf;

  // Decode of the instruction currently held for execute
  logic               w_is_goto;
  logic               w_is_call;
  logic               w_is_ret;
  logic               w_is_cf;
  logic [c_PTR_W-1:0] w_sp_dec;
  logic [10:0]        w_tos;
  logic [10:0]        w_pc_inc;

  // Control-flow decode; a squashed slot holds NOP so it never redirects
  always_comb begin
    w_is_goto = (r_ir[13:11] == 3'b101);
    w_is_call = (r_ir[13:11] == 3'b100);
    w_is_ret  = (r_ir == 14'h0008) || (r_ir == 14'h0009) ||
                (r_ir[13:10] == 4'b1101);
    w_is_cf   = w_is_goto || w_is_call || w_is_ret;
    w_sp_dec  = r_sp - c_PTR_W'(1);
    w_tos     = r_stack[w_sp_dec];
    w_pc_inc  = r_pc + 11'd1;
  end

  // Pipeline registers: redirect beats skip beats sequential fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= 11'd0;
      r_ir       <= c_NOP;
      r_ir_addr  <= 11'd0;
      r_ir_valid <= 1'b0;
    end else if (!stall) begin
      if (w_is_cf) begin
        r_ir       <= c_NOP;
        r_ir_valid <= 1'b0;
        if (w_is_ret) begin
          r_pc <= w_tos;
        end else begin
          r_pc <= r_ir[10:0];
        end
      end else if (skip) begin
        r_ir       <= c_NOP;
        r_ir_valid <= 1'b0;
        r_ir_addr  <= r_pc;
        r_pc       <= w_pc_inc;
      end else begin
        r_ir       <= rom_data;
        r_ir_valid <= 1'b1;
        r_ir_addr  <= r_pc;
        r_pc       <= w_pc_inc;
      end
    end
  end

  // Stack pointer, occupancy and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_occ <= c_EMPTY;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!stall) begin
      if (w_is_call) begin
        r_sp <= r_sp + c_PTR_W'(1);
        if (r_occ == c_FULL) begin
          r_ovf <= 1'b1;
        end else begin
          r_occ <= r_occ + c_OCC_W'(1);
        end
      end else if (w_is_ret) begin
        r_sp <= w_sp_dec;
        if (r_occ == c_EMPTY) begin
          r_unf <= 1'b1;
        end else begin
          r_occ <= r_occ - c_OCC_W'(1);
        end
      end
    end
  end

  // Stack storage write; r_ir is cleared by reset so no push happens then
  always_ff @(posedge clk) begin
    if (!stall && w_is_call) begin
      r_stack[r_sp] <= r_pc;
    end
  end

  assign rom_addr  = r_pc;
  assign ir        = r_ir;
  assign ir_addr   = r_ir_addr;
  assign ir_valid  = r_ir_valid;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        skip = 1'b0;
  logic [13:0] rom_data;
  logic [10:0] rom_addr;
  logic [13:0] ir;
  logic [10:0] ir_addr;
  logic        ir_valid;
  logic        stack_ovf;
  logic        stack_unf;

  logic [13:0] rom [0:2047];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_unit #(.STACK_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .skip     (skip),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .ir       (ir),
    .ir_addr  (ir_addr),
    .ir_valid (ir_valid),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [10:0] m_pc;
  logic [13:0] m_ir;
  logic [10:0] m_ir_addr;
  logic        m_valid;
  logic        m_ovf;
  logic        m_unf;
  logic [10:0] m_stk [8];
  int          m_sp;
  int          m_occ;
  logic [10:0] m_pops [$];

  function automatic logic [38:0] dut_v();
    return {rom_addr, ir, ir_addr, ir_valid, stack_ovf, stack_unf};
  endfunction

  function automatic logic [38:0] model_v();
    return {m_pc, m_ir, m_ir_addr, m_valid, m_ovf, m_unf};
  endfunction

  function automatic logic is_ret(input logic [13:0] w);
    return (w == 14'h0008) || (w == 14'h0009) || (w[13:10] == 4'b1101);
  endfunction

  task automatic model_reset();
    m_pc = 11'd0; m_ir = 14'h0000; m_ir_addr = 11'd0; m_valid = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_sp = 0; m_occ = 0;
  endtask

  task automatic model_step();
    logic [13:0] w;
    if (stall) return;
    w = m_ir;
    if (w[13:11] == 3'b101) begin
      m_pc = w[10:0]; m_ir = 14'h0000; m_valid = 1'b0;
    end else if (w[13:11] == 3'b100) begin
      if (m_occ == 8) m_ovf = 1'b1; else m_occ = m_occ + 1;
      m_stk[m_sp] = m_pc;
      m_sp = (m_sp + 1) % 8;
      m_pc = w[10:0]; m_ir = 14'h0000; m_valid = 1'b0;
    end else if (is_ret(w)) begin
      if (m_occ == 0) m_unf = 1'b1; else m_occ = m_occ - 1;
      m_sp = (m_sp + 7) % 8;
      m_pc = m_stk[m_sp];
      m_pops.push_back(m_pc);
      m_ir = 14'h0000; m_valid = 1'b0;
    end else if (skip) begin
      m_ir = 14'h0000; m_valid = 1'b0; m_ir_addr = m_pc; m_pc = m_pc + 11'd1;
    end else begin
      m_ir = rom[m_pc]; m_valid = 1'b1; m_ir_addr = m_pc; m_pc = m_pc + 11'd1;
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, settle
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; skip = 1'b0;
    model_reset();
    m_pops.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 14'h0123;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (dut_v() !== 39'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", dut_v(), 39'd0);
    end
    @(negedge clk);
    n_cmp++;
    if (dut_v() !== 39'd0) begin
      n_fail++; $display("FAIL reset_held: got %h want %h", dut_v(), 39'd0);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (ir !== 14'h0123 || ir_addr !== 11'd0 || rom_addr !== 11'd1 || ir_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_fetch: got ir=%h addr=%h pc=%h v=%b want ir=0123 addr=000 pc=001 v=1",
               ir, ir_addr, rom_addr, ir_valid);
    end
  endtask

  task automatic test_sequential();
    logic [13:0] exp_ir [3];
    exp_ir[0] = 14'h01A5; exp_ir[1] = 14'h0103; exp_ir[2] = 14'h3001;
    clear_rom();
    rom[0] = 14'h01A5; rom[1] = 14'h0103; rom[2] = 14'h3001;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ir !== exp_ir[i] || ir_addr !== 11'(i) || ir_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_ir[%0d]: got ir=%h addr=%h v=%b want ir=%h addr=%h v=1",
                 i, ir, ir_addr, ir_valid, exp_ir[i], 11'(i));
      end
      n_cmp++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL seq_model[%0d]: got %h want %h", i, dut_v(), model_v());
      end
    end
  endtask

  task automatic test_goto();
    clear_rom();
    rom[11'h012] = 14'h2804;
    rom[11'h004] = 14'h0ABC;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      tick();
      n_cmp++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL goto_model[%0d]: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_cmp++;
    if (ir !== 14'h2804 || ir_addr !== 11'h012) begin
      n_fail++; $display("FAIL goto_fetch: got ir=%h addr=%h want ir=2804 addr=012", ir, ir_addr);
    end
    tick();
    n_cmp++;
    if (ir !== 14'h0000 || ir_valid !== 1'b0) begin
      n_fail++; $display("FAIL goto_bubble: got ir=%h v=%b want ir=0000 v=0", ir, ir_valid);
    end
    tick();
    n_cmp++;
    if (ir !== 14'h0ABC || ir_addr !== 11'h004 || ir_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL goto_target: got ir=%h addr=%h v=%b want ir=0abc addr=004 v=1", ir, ir_addr, ir_valid);
    end
  endtask

  task automatic test_call_return();
    logic [10:0] exp_addr [8];
    logic        exp_val  [8];
    exp_addr = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h000, 11'h010, 11'h000, 11'h004};
    exp_val  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_rom();
    rom[11'h003] = 14'h2010;
    rom[11'h010] = 14'h0008;
    rom[11'h004] = 14'h0155;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (ir_valid !== exp_val[i] || (exp_val[i] && ir_addr !== exp_addr[i])) begin
        n_fail++;
        $display("FAIL call_flow[%0d]: got addr=%h v=%b want addr=%h v=%b",
                 i, ir_addr, ir_valid, exp_addr[i], exp_val[i]);
      end
      n_cmp++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL call_model[%0d]: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_cmp++;
    if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      n_fail++; $display("FAIL call_flags: got ovf=%b unf=%b want 0 0", stack_ovf, stack_unf);
    end
  endtask

  task automatic test_stack_overflow();
    logic [10:0] seen [$];
    clear_rom();
    rom[0] = 14'h2900;
    for (int k = 0; k < 9; k++) begin
      rom[11'h100 + 11'(16 * k)] = 14'h2000 | 14'(11'h110 + 11'(16 * k));
      rom[11'h101 + 11'(16 * k)] = 14'h0008;
    end
    rom[11'h190] = 14'h0008;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      tick();
      n_cmp++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL ovf_model[%0d]: got %h want %h", i, dut_v(), model_v());
      end
      if (ir_valid && ir == 14'h0008 && ir_addr[3:0] == 4'h1) seen.push_back(ir_addr);
    end
    n_cmp++;
    if (seen.size() < 9 || m_pops.size() < 9) begin
      n_fail++; $display("FAIL ovf_pop_count: got %0d want >= 9", seen.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (seen[i] !== 11'(11'h181 - 11'(16 * i))) begin
          n_fail++; $display("FAIL ovf_pop_order[%0d]: got %h want %h", i, seen[i], 11'(11'h181 - 11'(16 * i)));
        end
      end
      n_cmp++;
      if (seen[8] !== m_pops[8]) begin
        n_fail++; $display("FAIL ovf_pop9: got %h want %h", seen[8], m_pops[8]);
      end
    end
    n_cmp++;
    if (stack_ovf !== 1'b1 || stack_unf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flags: got ovf=%b unf=%b want 1 1", stack_ovf, stack_unf);
    end
  endtask

  task automatic test_skip();
    clear_rom();
    rom[11'h011] = 14'h1FA5;
    rom[11'h013] = 14'h2820;
    rom[11'h020] = 14'h0321;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick();
      n_cmp++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL skip_model[%0d]: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_cmp++;
    if (ir !== 14'h1FA5 || ir_addr !== 11'h011) begin
      n_fail++; $display("FAIL skip_pre: got ir=%h addr=%h want ir=1fa5 addr=011", ir, ir_addr);
    end
    skip = 1'b1;
    tick();
    n_cmp++;
    if (ir !== 14'h0000 || ir_valid !== 1'b0 || ir_addr !== 11'h012) begin
      n_fail++;
      $display("FAIL skip_squash: got ir=%h addr=%h v=%b want ir=0000 addr=012 v=0", ir, ir_addr, ir_valid);
    end
    skip = 1'b0;
    tick();
    n_cmp++;
    if (ir !== 14'h2820 || ir_addr !== 11'h013 || ir_valid !== 1'b1) begin
      n_fail++; $display("FAIL skip_next: got ir=%h addr=%h v=%b want ir=2820 addr=013 v=1", ir, ir_addr, ir_valid);
    end
    skip = 1'b1;
    tick();
    skip = 1'b0;
    tick();
    n_cmp++;
    if (ir !== 14'h0321 || ir_addr !== 11'h020 || dut_v() !== model_v()) begin
      n_fail++; $display("FAIL skip_vs_goto: got %h want %h", dut_v(), model_v());
    end
  endtask

  task automatic test_stall_wrap();
    clear_rom();
    rom[5] = 14'h0BA2;
    do_reset();
    repeat (6) tick();
    n_cmp++;
    if (ir !== 14'h0BA2 || ir_addr !== 11'd5) begin
      n_fail++; $display("FAIL stall_pre: got ir=%h addr=%h want ir=0ba2 addr=005", ir, ir_addr);
    end
    stall = 1'b1;
    skip  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ir !== 14'h0BA2 || rom_addr !== 11'd6 || ir_addr !== 11'd5 || ir_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got ir=%h pc=%h addr=%h v=%b want ir=0ba2 pc=006 addr=005 v=1",
                 i, ir, rom_addr, ir_addr, ir_valid);
      end
    end
    stall = 1'b0;
    skip  = 1'b0;
    tick();
    n_cmp++;
    if (ir_addr !== 11'd6 || ir_valid !== 1'b1 || rom_addr !== 11'd7) begin
      n_fail++; $display("FAIL stall_release: got addr=%h pc=%h want addr=006 pc=007", ir_addr, rom_addr);
    end
    clear_rom();
    rom[0]       = 14'h2FFE;
    rom[11'h7FF] = 14'h0777;
    do_reset();
    repeat (4) tick();
    n_cmp++;
    if (ir !== 14'h0777 || ir_addr !== 11'h7FF || rom_addr !== 11'h000) begin
      n_fail++; $display("FAIL pc_wrap: got ir=%h addr=%h pc=%h want ir=0777 addr=7ff pc=000", ir, ir_addr, rom_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2048; i++) rom[i] = 14'($urandom);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom % 5) == 0;
      skip  = ($urandom % 4) == 0;
      tick();
      n_cmp++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL rand_model[%0d]: got %h want %h", i, dut_v(), model_v());
      end
    end
    stall = 1'b0;
    skip  = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0]       = 14'h2040;
    rom[1]       = 14'h0008;
    rom[11'h040] = 14'h0008;
    do_reset();
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (dut_v() !== 39'd0) begin
      n_fail++; $display("FAIL rst_mid_call: got %h want %h", dut_v(), 39'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++;
    if (ir !== 14'h2040 || ir_addr !== 11'd0 || rom_addr !== 11'd1) begin
      n_fail++; $display("FAIL rst_refetch: got ir=%h addr=%h pc=%h want ir=2040 addr=000 pc=001", ir, ir_addr, rom_addr);
    end
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (dut_v() !== 39'd0) begin
      n_fail++; $display("FAIL rst_mid_ret: got %h want %h", dut_v(), 39'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL rst_after_model[%0d]: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_cmp++;
    if (stack_unf !== 1'b1 || stack_ovf !== 1'b0) begin
      n_fail++; $display("FAIL rst_occupancy: got unf=%b ovf=%b want unf=1 ovf=0", stack_unf, stack_ovf);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) m_stk[i] = 11'd0;
    model_reset();
    test_reset();
    test_sequential();
    test_goto();
    test_call_return();
    test_stack_overflow();
    test_skip();
    test_stall_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
